// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a writing producer targets the given source register ($0 never matches).
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] dst,
                                       input logic [4:0] src);
        return we && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding-mux select pair; M has priority over W.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] register_s_e,
    input  logic [4:0] register_t_e,
    input  logic [4:0] write_reg_m,
    input  logic       reg_write_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_w,
    output fwd_sel_t   forward_a_e,
    output fwd_sel_t   forward_b_e
);

    // Select the youngest producer for each EX source operand.
    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        if (reg_match(reg_write_m, write_reg_m, register_s_e)) begin
            forward_a_e = FWD_M;
        end else if (reg_match(reg_write_w, write_reg_w, register_s_e)) begin
            forward_a_e = FWD_W;
        end else begin
            forward_a_e = FWD_RF;
        end
        if (reg_match(reg_write_m, write_reg_m, register_t_e)) begin
            forward_b_e = FWD_M;
        end else if (reg_match(reg_write_w, write_reg_w, register_t_e)) begin
            forward_b_e = FWD_W;
        end else begin
            forward_b_e = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use/RAW stalls, branch squash, MDU hold.
// Optional feature macro: FORWARDING_EN (EX forwarding; only load-use then stalls).
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       register_s_d,
    input  logic [4:0]       register_t_d,
    input  logic [4:0]       register_s_e,
    input  logic [4:0]       register_t_e,
    input  logic [4:0]       write_reg_e,
    input  logic             reg_write_e,
    input  logic             mem_rd_en_e,
    input  logic [4:0]       write_reg_m,
    input  logic             reg_write_m,
    input  logic [4:0]       write_reg_w,
    input  logic             reg_write_w,
    input  logic             branch_taken_d,
    input  logic             mdu_start_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             stall_e,
    output logic             flush_e,
    output logic             flush_m,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int             CW        = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
    localparam logic           MDU_MULTI = (MDU_LATENCY > 1);
    localparam logic [CW-1:0]  CNT_LOAD  = CW'((MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    hz_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic     busy_s;
    logic     load_use_s;
    logic     raw_s;
    logic     hazard_s;
    fwd_sel_t fwd_a_s;
    fwd_sel_t fwd_b_s;

    assign busy_s     = (state_q == MDU_BUSY);
    assign load_use_s = mem_rd_en_e && (write_reg_e != REG_ZERO) &&
                        ((write_reg_e == register_s_d) || (write_reg_e == register_t_d));
    assign hazard_s   = load_use_s || raw_s;

`ifdef FORWARDING_EN
    logic unused_nofwd_s;

    assign raw_s          = 1'b0;
    assign unused_nofwd_s = reg_write_e;

    fwd_unit u_fwd_unit (
        .register_s_e (register_s_e),
        .register_t_e (register_t_e),
        .write_reg_m  (write_reg_m),
        .reg_write_m  (reg_write_m),
        .write_reg_w  (write_reg_w),
        .reg_write_w  (reg_write_w),
        .forward_a_e  (fwd_a_s),
        .forward_b_e  (fwd_b_s)
    );
`else
    logic unused_fwd_s;

    // Without forwarding, D must wait until an E or M producer has reached W.
    assign raw_s = reg_match(reg_write_e, write_reg_e, register_s_d) ||
                   reg_match(reg_write_e, write_reg_e, register_t_d) ||
                   reg_match(reg_write_m, write_reg_m, register_s_d) ||
                   reg_match(reg_write_m, write_reg_m, register_t_d);
    assign fwd_a_s      = FWD_RF;
    assign fwd_b_s      = FWD_RF;
    assign unused_fwd_s = ^{register_s_e, register_t_e, write_reg_w, reg_write_w};
`endif

    // MDU occupancy FSM and down-counter next state; new starts are ignored while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mdu_start_e && MDU_MULTI) begin
                    state_d = MDU_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            MDU_BUSY: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Saturating count of cycles in which D is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((busy_s || hazard_s) && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, MDU counter and performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= {CW{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Pipeline controls: MDU hold beats hazard stall beats branch flush; all quiet in reset.
    always_comb begin
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        flush_d      = 1'b0;
        stall_e      = 1'b0;
        flush_e      = 1'b0;
        flush_m      = 1'b0;
        forward_a_e  = 2'b00;
        forward_b_e  = 2'b00;
        mdu_busy     = 1'b0;
        stall_cycles = {CNT_W{1'b0}};
        if (reset) begin
            stall_cycles = {CNT_W{1'b0}};
        end else begin
            forward_a_e  = fwd_a_s;
            forward_b_e  = fwd_b_s;
            mdu_busy     = busy_s;
            stall_cycles = stall_cnt_q;
            if (busy_s) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (hazard_s) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                flush_d = branch_taken_d;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    register_s_d, register_t_d, register_s_e, register_t_e;
    logic [4:0]    write_reg_e, write_reg_m, write_reg_w;
    logic          reg_write_e, mem_rd_en_e, reg_write_m, reg_write_w;
    logic          branch_taken_d, mdu_start_e;
    logic          stall_f, stall_d, flush_d, stall_e, flush_e, flush_m, mdu_busy;
    logic [1:0]    forward_a_e, forward_b_e;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .register_s_d(register_s_d), .register_t_d(register_t_d),
        .register_s_e(register_s_e), .register_t_e(register_t_e),
        .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_rd_en_e(mem_rd_en_e),
        .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
        .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
        .branch_taken_d(branch_taken_d), .mdu_start_e(mdu_start_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit       rst;
        bit [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        bit       rw_e, ld_e, rw_m, rw_w, br, mdu;
    } stim_t;

    typedef struct {
        int sf, sd, fd, se, fe, fm, fa, fb, busy, cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   busy_left = 0;
    int   stall_count = 0;

    function automatic bit writes(bit we, bit [4:0] dst, bit [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic int fwd_sel(stim_t s, bit [4:0] src);
        if (!FWD)                      return 0;
        if (writes(s.rw_m, s.wr_m, src)) return 2;
        if (writes(s.rw_w, s.wr_w, src)) return 1;
        return 0;
    endfunction

    // Behavioural model: outputs for this cycle, then advance the model across the clock edge.
    task automatic predict(input stim_t s, output exp_t e);
        bit hz, lu, raw, stall;
        e = '{default: 0};
        if (s.rst) begin
            busy_left   = 0;
            stall_count = 0;
            return;
        end
        e.fa  = fwd_sel(s, s.rs_e);
        e.fb  = fwd_sel(s, s.rt_e);
        e.cyc = stall_count;
        stall = 1'b0;
        if (busy_left > 0) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1; e.busy = 1;
            stall = 1'b1;
            busy_left--;
        end else begin
            lu  = s.ld_e && s.wr_e != 5'd0 && (s.wr_e == s.rs_d || s.wr_e == s.rt_d);
            raw = !FWD && (writes(s.rw_e, s.wr_e, s.rs_d) || writes(s.rw_e, s.wr_e, s.rt_d) ||
                           writes(s.rw_m, s.wr_m, s.rs_d) || writes(s.rw_m, s.wr_m, s.rt_d));
            hz  = lu || raw;
            e.sf = hz; e.sd = hz; e.fe = hz;
            e.fd = s.br && !hz;
            stall = hz;
            if (s.mdu && LAT > 1) busy_left = LAT - 1;
        end
        if (stall && stall_count < SMAX) stall_count++;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset = s.rst;
        register_s_d = s.rs_d; register_t_d = s.rt_d;
        register_s_e = s.rs_e; register_t_e = s.rt_e;
        write_reg_e = s.wr_e; reg_write_e = s.rw_e; mem_rd_en_e = s.ld_e;
        write_reg_m = s.wr_m; reg_write_m = s.rw_m;
        write_reg_w = s.wr_w; reg_write_w = s.rw_w;
        branch_taken_d = s.br; mdu_start_e = s.mdu;
        predict(s, e);
        sb_q.push_back(e);
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a settled output every cycle; compare away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("stall_f", 32'(stall_f), e.sf);
            chk("stall_d", 32'(stall_d), e.sd);
            chk("flush_d", 32'(flush_d), e.fd);
            chk("stall_e", 32'(stall_e), e.se);
            chk("flush_e", 32'(flush_e), e.fe);
            chk("flush_m", 32'(flush_m), e.fm);
            chk("forward_a_e", 32'(forward_a_e), e.fa);
            chk("forward_b_e", 32'(forward_b_e), e.fb);
            chk("mdu_busy", 32'(mdu_busy), e.busy);
            chk("stall_cycles", 32'(stall_cycles), e.cyc);
        end
    end

    initial begin
        stim_t s;
        s = quiet();
        reset = 1'b1;
        {register_s_d, register_t_d, register_s_e, register_t_e} = 20'd0;
        {write_reg_e, write_reg_m, write_reg_w} = 15'd0;
        {reg_write_e, mem_rd_en_e, reg_write_m, reg_write_w, branch_taken_d, mdu_start_e} = 6'd0;

        s.rst = 1'b1;
        repeat (3) drive(s);

        // lw $2 in E, add $3,$2,$4 in D; then load advances to M
        s = quiet(); s.ld_e = 1; s.rw_e = 1; s.wr_e = 5'd2; s.rs_d = 5'd2; s.rt_d = 5'd4;
        drive(s);
        s = quiet(); s.rw_m = 1; s.wr_m = 5'd2; s.rs_d = 5'd2; s.rt_d = 5'd4;
        drive(s);
        drive(quiet());

        // forwarding selects: M and W both write $5, then M targets $0
        s = quiet(); s.rw_m = 1; s.wr_m = 5'd5; s.rs_e = 5'd5; s.rw_w = 1; s.wr_w = 5'd5; s.rt_e = 5'd5;
        drive(s);
        s.wr_m = 5'd0;
        drive(s);
        s = quiet(); s.rw_w = 1; s.wr_w = 5'd9; s.rt_e = 5'd9;
        drive(s);

        // MDU op: full busy window, then a second op aborted by reset in its 2nd busy cycle
        s = quiet(); s.mdu = 1;
        drive(s);
        s.mdu = 0; s.br = 1;
        repeat (4) drive(s);
        s = quiet(); s.mdu = 1;
        drive(s);
        drive(quiet());
        s = quiet(); s.rst = 1;
        drive(s);
        repeat (2) drive(quiet());

        // branch and load-use together, then branch alone
        s = quiet(); s.br = 1; s.ld_e = 1; s.rw_e = 1; s.wr_e = 5'd6; s.rt_d = 5'd6;
        drive(s);
        s = quiet(); s.br = 1;
        drive(s);

        // ALU producer of $7 walking E->M->W; then a write to $0
        s = quiet(); s.rw_e = 1; s.wr_e = 5'd7; s.rs_d = 5'd7;
        drive(s);
        s = quiet(); s.rw_m = 1; s.wr_m = 5'd7; s.rs_d = 5'd7;
        drive(s);
        s = quiet(); s.rw_w = 1; s.wr_w = 5'd7; s.rs_d = 5'd7;
        drive(s);
        s = quiet(); s.rw_e = 1; s.wr_e = 5'd0; s.ld_e = 1; s.rs_d = 5'd0; s.rt_d = 5'd0;
        drive(s);

        // 20 consecutive stall cycles: counter saturates
        s = quiet(); s.ld_e = 1; s.rw_e = 1; s.wr_e = 5'd3; s.rs_d = 5'd3;
        repeat (20) drive(s);
        drive(quiet());

        // random traffic over a small register window to make collisions frequent
        s = quiet(); s.rst = 1;
        drive(s);
        for (int i = 0; i < 400; i++) begin
            s.rst  = ($urandom_range(0, 59) == 0);
            s.rs_d = 5'($urandom_range(0, 7)); s.rt_d = 5'($urandom_range(0, 7));
            s.rs_e = 5'($urandom_range(0, 7)); s.rt_e = 5'($urandom_range(0, 7));
            s.wr_e = 5'($urandom_range(0, 7)); s.wr_m = 5'($urandom_range(0, 7));
            s.wr_w = 5'($urandom_range(0, 7));
            s.rw_e = 1'($urandom_range(0, 1)); s.rw_m = 1'($urandom_range(0, 1));
            s.rw_w = 1'($urandom_range(0, 1));
            s.ld_e = ($urandom_range(0, 3) == 0);
            s.br   = ($urandom_range(0, 3) == 0);
            s.mdu  = ($urandom_range(0, 11) == 0);
            drive(s);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
